// File: rtl/frogger_pkg.sv
// Shared constants for the Frogger game sequencer: state encodings, frog origin,
// grid limits and default timing values.
package frogger_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PLAY      = 3'd1;
  localparam logic [2:0] ST_DYING     = 3'd2;
  localparam logic [2:0] ST_LEVEL_UP  = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;
  localparam logic [2:0] ST_PAUSED    = 3'd5;

  localparam int FROG_ORIGIN_X = 11;
  localparam int FROG_ORIGIN_Y = 14;
  localparam int GRID_X_MAX    = 22;
  localparam int GRID_Y_MAX    = 14;

  localparam int TICKS_PER_SEC_DEF  = 25000000;
  localparam int ROUND_SECS_DEF     = 30;
  localparam int START_LIVES_DEF    = 3;
  localparam int PADS_PER_LEVEL_DEF = 5;
  localparam int HOLD_CYCLES_DEF    = 12500000;
  localparam int SCORE_MAX_DEF      = 99;

  function automatic logic [6:0] sat_inc7(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim) ? lim : v + 7'd1;
  endfunction

endpackage

// File: rtl/frogger_game_seq_if.sv
// Event inputs and status outputs of the game sequencer.
// i_Pause exists only when FROGGER_PAUSE_EN is defined.
interface frogger_game_seq_if;
  logic       i_Start;
  logic       i_Collided;
  logic       i_Goal;
`ifdef FROGGER_PAUSE_EN
  logic       i_Pause;
`endif
  logic       o_Game_Active;
  logic       o_Frog_Respawn;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic [2:0] o_Level;
  logic [5:0] o_Time_Left;
  logic [2:0] o_Pads_Filled;
  logic [2:0] o_State;
  logic       o_Game_Over;

`ifdef FROGGER_PAUSE_EN
  modport master (output i_Start, i_Collided, i_Goal, i_Pause,
                  input  o_Game_Active, o_Frog_Respawn, o_Lives, o_Score, o_Level,
                         o_Time_Left, o_Pads_Filled, o_State, o_Game_Over);
  modport slave  (input  i_Start, i_Collided, i_Goal, i_Pause,
                  output o_Game_Active, o_Frog_Respawn, o_Lives, o_Score, o_Level,
                         o_Time_Left, o_Pads_Filled, o_State, o_Game_Over);
`else
  modport master (output i_Start, i_Collided, i_Goal,
                  input  o_Game_Active, o_Frog_Respawn, o_Lives, o_Score, o_Level,
                         o_Time_Left, o_Pads_Filled, o_State, o_Game_Over);
  modport slave  (input  i_Start, i_Collided, i_Goal,
                  output o_Game_Active, o_Frog_Respawn, o_Lives, o_Score, o_Level,
                         o_Time_Left, o_Pads_Filled, o_State, o_Game_Over);
`endif
endinterface

// File: rtl/frogger_round_timer.sv
// Per-life countdown: prescaler wraps every c_TICKS_PER_SEC enabled cycles and
// decrements the seconds count; a wrap at zero seconds raises o_Timeout.
module frogger_round_timer #(
  parameter int c_TICKS_PER_SEC = 25000000,
  parameter int c_ROUND_SECS    = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Load,
  input  logic       i_Enable,
  output logic [5:0] o_Time_Left,
  output logic       o_Timeout
);

  localparam int PW = (c_TICKS_PER_SEC > 1) ? $clog2(c_TICKS_PER_SEC) : 1;

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap      = i_Enable && (presc == PW'(c_TICKS_PER_SEC - 1));
  assign o_Timeout = wrap && (o_Time_Left == 6'd0);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      presc       <= '0;
      o_Time_Left <= 6'(c_ROUND_SECS);
    end else if (i_Load) begin
      presc       <= '0;
      o_Time_Left <= 6'(c_ROUND_SECS);
    end else if (wrap) begin
      presc <= '0;
      if (o_Time_Left != 6'd0) o_Time_Left <= o_Time_Left - 6'd1;
    end else if (i_Enable) begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/frogger_game_seq.sv
// Frogger game sequencer: state, lives, score, level, pads and round timer.
// Optional pause state when FROGGER_PAUSE_EN is defined.
module frogger_game_seq
  import frogger_pkg::*;
#(
  parameter int c_TICKS_PER_SEC  = TICKS_PER_SEC_DEF,
  parameter int c_ROUND_SECS     = ROUND_SECS_DEF,
  parameter int c_START_LIVES    = START_LIVES_DEF,
  parameter int c_PADS_PER_LEVEL = PADS_PER_LEVEL_DEF,
  parameter int c_HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int c_SCORE_MAX      = SCORE_MAX_DEF
) (
  input logic               i_Clk,
  input logic               i_Rst,
  frogger_game_seq_if.slave bus
);

  localparam int HW = (c_HOLD_CYCLES > 1) ? $clog2(c_HOLD_CYCLES) : 1;

  logic [2:0]    state, state_nxt;
  logic          start_q, start_edge, pause_edge;
  logic [HW-1:0] hold_cnt;
  logic          in_hold, hold_done;
  logic          tmr_load, tmr_en, timeout, death, goal_ok;
  logic [1:0]    lives;
  logic [6:0]    score;
  logic [2:0]    level, pads;
  logic          respawn, active, over;

  assign start_edge = bus.i_Start & ~start_q;

`ifdef FROGGER_PAUSE_EN
  logic pause_q;
  assign pause_edge = bus.i_Pause & ~pause_q;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) pause_q <= 1'b0;
    else       pause_q <= bus.i_Pause;
`else
  assign pause_edge = 1'b0;
`endif

  assign in_hold   = (state == ST_DYING) || (state == ST_LEVEL_UP);
  assign hold_done = in_hold && (hold_cnt == HW'(c_HOLD_CYCLES - 1));
  // Collision and a pause edge both freeze the tick for that cycle.
  assign tmr_en    = (state == ST_PLAY) && !bus.i_Collided && !pause_edge;

  frogger_round_timer #(
    .c_TICKS_PER_SEC(c_TICKS_PER_SEC),
    .c_ROUND_SECS   (c_ROUND_SECS)
  ) u_timer (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (tmr_load),
    .i_Enable   (tmr_en),
    .o_Time_Left(bus.o_Time_Left),
    .o_Timeout  (timeout)
  );

  // Every timer reload coincides with a frog respawn, so one strobe serves both.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    death     = 1'b0;
    goal_ok   = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER:
        if (start_edge) begin
          state_nxt = ST_PLAY;
          tmr_load  = 1'b1;
        end
      ST_PLAY: begin
        death   = bus.i_Collided || timeout;
        goal_ok = bus.i_Goal && !death;
        if (death) state_nxt = ST_DYING;
        else if (goal_ok) begin
          tmr_load = 1'b1;
          if (pads == 3'(c_PADS_PER_LEVEL - 1)) state_nxt = ST_LEVEL_UP;
        end else if (pause_edge) state_nxt = ST_PAUSED;
      end
      ST_DYING:
        if (hold_done) begin
          if (lives != 2'd0) begin
            state_nxt = ST_PLAY;
            tmr_load  = 1'b1;
          end else state_nxt = ST_GAME_OVER;
        end
      ST_LEVEL_UP:
        if (hold_done) begin
          state_nxt = ST_PLAY;
          tmr_load  = 1'b1;
        end
`ifdef FROGGER_PAUSE_EN
      ST_PAUSED:
        if (pause_edge) state_nxt = ST_PLAY;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= ST_IDLE;
      start_q  <= 1'b0;
      hold_cnt <= '0;
      lives    <= 2'(c_START_LIVES);
      score    <= 7'd0;
      level    <= 3'd0;
      pads     <= 3'd0;
      respawn  <= 1'b0;
      active   <= 1'b0;
      over     <= 1'b0;
    end else begin
      state    <= state_nxt;
      start_q  <= bus.i_Start;
      hold_cnt <= (in_hold && !hold_done) ? hold_cnt + HW'(1) : '0;
      respawn  <= tmr_load;
      active   <= (state_nxt == ST_PLAY);
      over     <= (state_nxt == ST_GAME_OVER);
      case (state)
        ST_IDLE, ST_GAME_OVER:
          if (start_edge) begin
            lives <= 2'(c_START_LIVES);
            score <= 7'd0;
            level <= 3'd0;
            pads  <= 3'd0;
          end
        ST_PLAY:
          if (death) lives <= lives - 2'd1;
          else if (goal_ok) begin
            score <= sat_inc7(score, 7'(c_SCORE_MAX));
            pads  <= pads + 3'd1;
          end
        ST_LEVEL_UP:
          if (hold_done) begin
            level <= (level == 3'd7) ? level : level + 3'd1;
            pads  <= 3'd0;
          end
        default: ;
      endcase
    end
  end

  assign bus.o_Game_Active  = active;
  assign bus.o_Frog_Respawn = respawn;
  assign bus.o_Lives        = lives;
  assign bus.o_Score        = score;
  assign bus.o_Level        = level;
  assign bus.o_Pads_Filled  = pads;
  assign bus.o_State        = state;
  assign bus.o_Game_Over    = over;

endmodule

// File: tb/tb_frogger_game_seq.sv
// Directed bench for frogger_game_seq: dut_a uses slow ticks for scoring and
// level tests, dut_b uses 4-cycle seconds and 2-second rounds for time-outs.
module tb_frogger_game_seq;
  import frogger_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frogger_game_seq_if a();
  frogger_game_seq_if b();

  frogger_game_seq #(.c_TICKS_PER_SEC(1000), .c_ROUND_SECS(30), .c_START_LIVES(3),
    .c_PADS_PER_LEVEL(5), .c_HOLD_CYCLES(3), .c_SCORE_MAX(99))
    dut_a (.i_Clk(clk), .i_Rst(rst), .bus(a));

  frogger_game_seq #(.c_TICKS_PER_SEC(4), .c_ROUND_SECS(2), .c_START_LIVES(3),
    .c_PADS_PER_LEVEL(5), .c_HOLD_CYCLES(3), .c_SCORE_MAX(99))
    dut_b (.i_Clk(clk), .i_Rst(rst), .bus(b));

  int pass = 0;
  int total = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    tick(2);
    total++; if (a.o_State !== ST_IDLE) $display("FAIL rst_state got %0d want 0", a.o_State); else pass++;
    total++; if (a.o_Lives !== 2'd3) $display("FAIL rst_lives got %0d want 3", a.o_Lives); else pass++;
    total++; if (a.o_Score !== 7'd0 || a.o_Level !== 3'd0 || a.o_Pads_Filled !== 3'd0)
      $display("FAIL rst_counts got s=%0d l=%0d p=%0d want 0", a.o_Score, a.o_Level, a.o_Pads_Filled); else pass++;
    total++; if (a.o_Time_Left !== 6'd30 || b.o_Time_Left !== 6'd2)
      $display("FAIL rst_time got %0d/%0d want 30/2", a.o_Time_Left, b.o_Time_Left); else pass++;
    total++; if (a.o_Game_Active !== 1'b0 || a.o_Frog_Respawn !== 1'b0 || a.o_Game_Over !== 1'b0)
      $display("FAIL rst_flags got %b%b%b want 000", a.o_Game_Active, a.o_Frog_Respawn, a.o_Game_Over); else pass++;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_start;
    int pulses = 0;
    a.i_Start = 1'b1;
    tick(1);
    total++; if (a.o_State !== ST_PLAY || a.o_Game_Active !== 1'b1)
      $display("FAIL start_state got %0d act=%b want 1 act=1", a.o_State, a.o_Game_Active); else pass++;
    total++; if (a.o_Lives !== 2'd3 || a.o_Score !== 7'd0 || a.o_Time_Left !== 6'd30)
      $display("FAIL start_load got l=%0d s=%0d t=%0d want 3/0/30", a.o_Lives, a.o_Score, a.o_Time_Left); else pass++;
    total++; if (a.o_Frog_Respawn !== 1'b1) $display("FAIL start_respawn got %b want 1", a.o_Frog_Respawn); else pass++;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (a.o_Frog_Respawn === 1'b1) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL start_held got %0d extra pulses want 0", pulses); else pass++;
    a.i_Start = 1'b0;
    tick(1);
    a.i_Start = 1'b1;
    tick(1);
    a.i_Start = 1'b0;
    total++; if (a.o_State !== ST_PLAY || a.o_Frog_Respawn !== 1'b0)
      $display("FAIL start_in_play got st=%0d rsp=%b want 1/0", a.o_State, a.o_Frog_Respawn); else pass++;
  endtask

  task automatic test_level_up;
    for (int k = 1; k <= 5; k++) begin
      a.i_Goal = 1'b1;
      tick(1);
      a.i_Goal = 1'b0;
      total++; if (a.o_Score !== 7'(k) || a.o_Pads_Filled !== 3'(k) || a.o_Frog_Respawn !== 1'b1)
        $display("FAIL goal_%0d got s=%0d p=%0d rsp=%b want %0d/%0d/1", k, a.o_Score, a.o_Pads_Filled, a.o_Frog_Respawn, k, k); else pass++;
      if (k < 5) tick(1);
    end
    total++; if (a.o_State !== ST_LEVEL_UP || a.o_Game_Active !== 1'b0)
      $display("FAIL lvl_enter got st=%0d act=%b want 3/0", a.o_State, a.o_Game_Active); else pass++;
    tick(2);
    total++; if (a.o_State !== ST_LEVEL_UP) $display("FAIL lvl_hold got %0d want 3", a.o_State); else pass++;
    tick(1);
    total++; if (a.o_State !== ST_PLAY || a.o_Level !== 3'd1 || a.o_Pads_Filled !== 3'd0 || a.o_Frog_Respawn !== 1'b1)
      $display("FAIL lvl_exit got st=%0d lv=%0d p=%0d rsp=%b want 1/1/0/1", a.o_State, a.o_Level, a.o_Pads_Filled, a.o_Frog_Respawn); else pass++;
    tick(1);
  endtask

  task automatic test_collide_goal;
    a.i_Collided = 1'b1;
    a.i_Goal = 1'b1;
    tick(1);
    a.i_Goal = 1'b0;
    total++; if (a.o_State !== ST_DYING || a.o_Lives !== 2'd2 || a.o_Score !== 7'd5 || a.o_Frog_Respawn !== 1'b0)
      $display("FAIL death_goal got st=%0d l=%0d s=%0d rsp=%b want 2/2/5/0", a.o_State, a.o_Lives, a.o_Score, a.o_Frog_Respawn); else pass++;
    tick(1);
    a.i_Collided = 1'b0;
    total++; if (a.o_State !== ST_DYING || a.o_Lives !== 2'd2)
      $display("FAIL dying_ignore got st=%0d l=%0d want 2/2", a.o_State, a.o_Lives); else pass++;
    tick(2);
    total++; if (a.o_State !== ST_PLAY || a.o_Time_Left !== 6'd30 || a.o_Frog_Respawn !== 1'b1 || a.o_Lives !== 2'd2)
      $display("FAIL dying_exit got st=%0d t=%0d rsp=%b l=%0d want 1/30/1/2", a.o_State, a.o_Time_Left, a.o_Frog_Respawn, a.o_Lives); else pass++;
  endtask

  task automatic test_score_sat;
    int issued = 0;
    int n = 0;
    while (issued < 94 && n < 3000) begin
      tick(1); n++;
      if (a.o_State === ST_PLAY && a.i_Goal === 1'b0 && a.o_Frog_Respawn === 1'b0) begin
        a.i_Goal = 1'b1; issued++;
      end else a.i_Goal = 1'b0;
    end
    tick(1);
    a.i_Goal = 1'b0;
    total++; if (issued != 94 || a.o_Score !== 7'd99)
      $display("FAIL score_99 got s=%0d goals=%0d want 99/94", a.o_Score, issued); else pass++;
    n = 0;
    while ((a.o_State !== ST_PLAY || a.o_Frog_Respawn !== 1'b0) && n < 50) begin tick(1); n++; end
    a.i_Goal = 1'b1;
    tick(1);
    a.i_Goal = 1'b0;
    total++; if (a.o_Score !== 7'd99 || a.o_Pads_Filled !== 3'd5 || a.o_State !== ST_LEVEL_UP)
      $display("FAIL score_sat got s=%0d p=%0d st=%0d want 99/5/3", a.o_Score, a.o_Pads_Filled, a.o_State); else pass++;
    tick(3);
    total++; if (a.o_Level !== 3'd7 || a.o_State !== ST_PLAY)
      $display("FAIL level_sat got lv=%0d st=%0d want 7/1", a.o_Level, a.o_State); else pass++;
  endtask

  task automatic test_reset_mid_dying;
    a.i_Collided = 1'b1;
    tick(1);
    a.i_Collided = 1'b0;
    total++; if (a.o_State !== ST_DYING || a.o_Lives !== 2'd1)
      $display("FAIL pre_rst_dying got st=%0d l=%0d want 2/1", a.o_State, a.o_Lives); else pass++;
    #2 rst = 1'b1;
    #1;
    total++; if (a.o_State !== ST_IDLE || a.o_Lives !== 2'd3 || a.o_Score !== 7'd0 || a.o_Level !== 3'd0 ||
                 a.o_Pads_Filled !== 3'd0 || a.o_Time_Left !== 6'd30 || a.o_Frog_Respawn !== 1'b0 ||
                 a.o_Game_Active !== 1'b0 || a.o_Game_Over !== 1'b0)
      $display("FAIL async_rst got st=%0d l=%0d s=%0d lv=%0d p=%0d t=%0d rsp=%b act=%b ov=%b want 0/3/0/0/0/30/0/0/0",
               a.o_State, a.o_Lives, a.o_Score, a.o_Level, a.o_Pads_Filled, a.o_Time_Left,
               a.o_Frog_Respawn, a.o_Game_Active, a.o_Game_Over); else pass++;
    tick(1);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_timeout;
    b.i_Start = 1'b1;
    tick(1);
    b.i_Start = 1'b0;
    total++; if (b.o_State !== ST_PLAY || b.o_Time_Left !== 6'd2 || b.o_Frog_Respawn !== 1'b1)
      $display("FAIL b_start got st=%0d t=%0d rsp=%b want 1/2/1", b.o_State, b.o_Time_Left, b.o_Frog_Respawn); else pass++;
    tick(3);
    total++; if (b.o_Time_Left !== 6'd2) $display("FAIL tmr_pre got %0d want 2", b.o_Time_Left); else pass++;
    tick(1);
    total++; if (b.o_Time_Left !== 6'd1) $display("FAIL tmr_1 got %0d want 1", b.o_Time_Left); else pass++;
    tick(4);
    total++; if (b.o_Time_Left !== 6'd0) $display("FAIL tmr_0 got %0d want 0", b.o_Time_Left); else pass++;
    tick(3);
    total++; if (b.o_State !== ST_PLAY) $display("FAIL tmr_at_0 got st=%0d want 1", b.o_State); else pass++;
    tick(1);
    for (int life = 0; life < 3; life++) begin
      if (life > 0) tick(12);
      total++; if (b.o_State !== ST_DYING || b.o_Lives !== 2'(2 - life))
        $display("FAIL timeout_%0d got st=%0d l=%0d want 2/%0d", life, b.o_State, b.o_Lives, 2 - life); else pass++;
      tick(3);
      if (life < 2) begin
        total++; if (b.o_State !== ST_PLAY || b.o_Time_Left !== 6'd2 || b.o_Frog_Respawn !== 1'b1)
          $display("FAIL respawn_%0d got st=%0d t=%0d rsp=%b want 1/2/1", life, b.o_State, b.o_Time_Left, b.o_Frog_Respawn); else pass++;
      end else begin
        total++; if (b.o_State !== ST_GAME_OVER || b.o_Game_Over !== 1'b1 || b.o_Lives !== 2'd0 ||
                     b.o_Frog_Respawn !== 1'b0 || b.o_Game_Active !== 1'b0)
          $display("FAIL game_over got st=%0d ov=%b l=%0d rsp=%b act=%b want 4/1/0/0/0", b.o_State, b.o_Game_Over,
                   b.o_Lives, b.o_Frog_Respawn, b.o_Game_Active); else pass++;
      end
    end
    tick(5);
    total++; if (b.o_State !== ST_GAME_OVER || b.o_Frog_Respawn !== 1'b0)
      $display("FAIL over_hold got st=%0d rsp=%b want 4/0", b.o_State, b.o_Frog_Respawn); else pass++;
    b.i_Start = 1'b1;
    tick(1);
    b.i_Start = 1'b0;
    total++; if (b.o_State !== ST_PLAY || b.o_Lives !== 2'd3 || b.o_Game_Over !== 1'b0 || b.o_Frog_Respawn !== 1'b1)
      $display("FAIL restart got st=%0d l=%0d ov=%b rsp=%b want 1/3/0/1", b.o_State, b.o_Lives, b.o_Game_Over, b.o_Frog_Respawn); else pass++;
  endtask

`ifdef FROGGER_PAUSE_EN
  task automatic test_pause;
    int n = 0;
    a.i_Start = 1'b1;
    tick(1);
    a.i_Start = 1'b0;
    while (a.o_Time_Left !== 6'd17 && n < 20000) begin tick(1); n++; end
    a.i_Pause = 1'b1;
    tick(1);
    a.i_Pause = 1'b0;
    total++; if (a.o_State !== ST_PAUSED || a.o_Game_Active !== 1'b0)
      $display("FAIL pause_enter got st=%0d act=%b want 5/0", a.o_State, a.o_Game_Active); else pass++;
    a.i_Collided = 1'b1;
    tick(1);
    a.i_Collided = 1'b0;
    tick(2500);
    total++; if (a.o_State !== ST_PAUSED || a.o_Time_Left !== 6'd17 || a.o_Lives !== 2'd3)
      $display("FAIL pause_hold got st=%0d t=%0d l=%0d want 5/17/3", a.o_State, a.o_Time_Left, a.o_Lives); else pass++;
    a.i_Pause = 1'b1;
    tick(1);
    a.i_Pause = 1'b0;
    total++; if (a.o_State !== ST_PLAY || a.o_Time_Left !== 6'd17 || a.o_Frog_Respawn !== 1'b0 || a.o_Lives !== 2'd3)
      $display("FAIL pause_exit got st=%0d t=%0d rsp=%b l=%0d want 1/17/0/3", a.o_State, a.o_Time_Left, a.o_Frog_Respawn, a.o_Lives); else pass++;
  endtask
`endif

  initial begin
    a.i_Start = 1'b0; a.i_Collided = 1'b0; a.i_Goal = 1'b0;
    b.i_Start = 1'b0; b.i_Collided = 1'b0; b.i_Goal = 1'b0;
`ifdef FROGGER_PAUSE_EN
    a.i_Pause = 1'b0; b.i_Pause = 1'b0;
`endif
    test_reset();
    test_start();
    test_level_up();
    test_collide_goal();
    test_score_sat();
    test_reset_mid_dying();
    test_timeout();
`ifdef FROGGER_PAUSE_EN
    test_pause();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
